// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory bus between the fetch stage and instruction memory.
//   One outstanding request: a request is accepted on imem_o_req && imem_i_gnt,
//   its response returns later as imem_i_rvalid with imem_i_rdata.
//
//   imem_o_req     fetch request valid              (fetch -> memory)
//   imem_o_addr    word-aligned fetch address       (fetch -> memory)
//   imem_i_gnt     request accepted this cycle      (memory -> fetch)
//   imem_i_rvalid  response data valid             (memory -> fetch)
//   imem_i_rdata   response instruction word        (memory -> fetch)
//
//   master : the fetch unit
//   slave  : the instruction memory
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_o_req;
    logic [31:0] imem_o_addr;
    logic        imem_i_gnt;
    logic        imem_i_rvalid;
    logic [31:0] imem_i_rdata;

    modport master (
        output imem_o_req,
        output imem_o_addr,
        input  imem_i_gnt,
        input  imem_i_rvalid,
        input  imem_i_rdata
    );

    modport slave (
        input  imem_o_req,
        input  imem_o_addr,
        output imem_i_gnt,
        output imem_i_rvalid,
        output imem_i_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   rv32I instruction-fetch stage. Owns the PC, issues one word fetch at a time
//   over the imem bus, and holds the returned instruction in a one-entry buffer
//   that feeds regD. Freezes while ctrl stalls regF and redirects on a jump
//   taken in execute, discarding any wrong-path response still in flight.
//
//   Ports
//     clk                  clock, rising edge
//     rst                  asynchronous, active-high reset
//     fetch_i_stall        regF stall: downstream not accepting the buffer
//     execute_i_need_jump  redirect request from execute (highest priority)
//     execute_i_jump_pc    redirect target (bits [1:0] ignored)
//     imem                 instruction-memory bus (master side)
//     fetch_o_valid        buffer holds a valid instruction
//     fetch_o_pc           PC of the buffered instruction
//     fetch_o_instr        buffered instruction (NOP after reset)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_i_stall,
    input  logic                execute_i_need_jump,
    input  logic [31:0]         execute_i_jump_pc,
    fetch_unit_if.master        imem,
    output logic                fetch_o_valid,
    output logic [31:0]         fetch_o_pc,
    output logic [31:0]         fetch_o_instr
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // nothing outstanding, buffer empty
        WAIT = 2'd1,   // one request outstanding
        HOLD = 2'd2    // buffer holds an instruction for regD
    } state_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    state_t      state_r,  state_s;
    logic [31:0] pc_r,     pc_s;       // next fetch address
    logic [31:0] issued_r, issued_s;   // address of the outstanding request
    logic        kill_r,   kill_s;     // drop the next response (wrong path)
    logic        valid_r,  valid_s;
    logic [31:0] opc_r,    opc_s;
    logic [31:0] instr_r,  instr_s;

    logic        req_s;
    logic        fire_s;

    // Request whenever the buffer is free (or being drained this cycle), but
    // never in the same cycle as a redirect and never while reset is held.
    always_comb begin
        req_s = 1'b0;
        if (rst || execute_i_need_jump) begin
            req_s = 1'b0;
        end else if (state_r == IDLE) begin
            req_s = 1'b1;
        end else if ((state_r == HOLD) && !fetch_i_stall) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    assign fire_s           = req_s && imem.imem_i_gnt;
    assign imem.imem_o_req  = req_s;
    assign imem.imem_o_addr = pc_r;

    // Next-state and datapath update; the redirect overrides every other path.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        issued_s = issued_r;
        kill_s   = kill_r;
        valid_s  = valid_r;
        opc_s    = opc_r;
        instr_s  = instr_r;

        if (execute_i_need_jump) begin
            pc_s    = align_word(execute_i_jump_pc);
            valid_s = 1'b0;
            case (state_r)
                IDLE: state_s = IDLE;
                HOLD: state_s = IDLE;
                WAIT: begin
                    if (imem.imem_i_rvalid) begin
                        // Wrong-path data arrives now: drop it, nothing left in flight.
                        kill_s  = 1'b0;
                        state_s = IDLE;
                    end else begin
                        // Response still in flight: mark it for discard.
                        kill_s  = 1'b1;
                        state_s = WAIT;
                    end
                end
                default: state_s = IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    if (fire_s) begin
                        issued_s = pc_r;
                        pc_s     = pc_r + 32'd4;
                        state_s  = WAIT;
                    end else begin
                        state_s  = IDLE;
                    end
                end
                WAIT: begin
                    if (imem.imem_i_rvalid && !kill_r) begin
                        instr_s = imem.imem_i_rdata;
                        opc_s   = issued_r;
                        valid_s = 1'b1;
                        state_s = HOLD;
                    end else if (imem.imem_i_rvalid) begin
                        kill_s  = 1'b0;
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT;
                    end
                end
                HOLD: begin
                    if (fetch_i_stall) begin
                        state_s = HOLD;
                    end else if (fire_s) begin
                        // regD takes the buffer this edge while the next fetch goes out.
                        valid_s  = 1'b0;
                        issued_s = pc_r;
                        pc_s     = pc_r + 32'd4;
                        state_s  = WAIT;
                    end else begin
                        valid_s  = 1'b0;
                        state_s  = IDLE;
                    end
                end
                default: begin
                    valid_s = 1'b0;
                    kill_s  = 1'b0;
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            pc_r     <= align_word(RESET_PC);
            issued_r <= 32'h0000_0000;
            kill_r   <= 1'b0;
            valid_r  <= 1'b0;
            opc_r    <= 32'h0000_0000;
            instr_r  <= NOP_INSTR;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            issued_r <= issued_s;
            kill_r   <= kill_s;
            valid_r  <= valid_s;
            opc_r    <= opc_s;
            instr_r  <= instr_s;
        end
    end

    assign fetch_o_valid = valid_r;
    assign fetch_o_pc    = opc_r;
    assign fetch_o_instr = instr_r;

endmodule
